// File: rtl/gpu_result_unloader.sv
// Streams the GPU result region out of the unified RAM over valid/ready, with credit-checked reads.
// Optional CHECKSUM output (sum of streamed words) when UNLOAD_CHECKSUM_EN is defined.
module gpu_result_unloader #(
    parameter int unsigned NUM_WORDS   = 256,
    parameter int unsigned WORD_STRIDE = 4,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] BASE_ADDR,
    output logic [31:0] RAM_ADDR,
    input  logic [31:0] RAM_Q,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_DATA,
    output logic [7:0]  OUT_INDEX,
    output logic        OUT_LAST,
    output logic        BUSY,
    output logic        DONE
`ifdef UNLOAD_CHECKSUM_EN
    ,
    output logic [31:0] CHECKSUM
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned ISS_W = $clog2(NUM_WORDS + 1);
    localparam logic [ISS_W-1:0] LAST_ISSUE = ISS_W'(NUM_WORDS - 1);
    localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e             state_q;
    logic [ISS_W-1:0]   issue_cnt_q;
    logic [31:0]        ram_addr_q;
    logic [RD_LAT-1:0]  vpipe_q;
    logic [RD_LAT-1:0]  vpipe_d;
    logic [31:0]        fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   fifo_cnt_q;
    logic [7:0]         out_idx_q;
    logic               busy_q;
    logic               done_q;
    logic [31:0]        csum_q;

    logic               push;
    logic               pop;
    logic               issue;
    logic [SUM_W-1:0]   inflight;
    logic               credit_ok;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            inflight = inflight + SUM_W'(vpipe_q[i]);
        end
        push = vpipe_q[RD_LAT-1];
        pop  = (fifo_cnt_q != '0) && OUT_READY;
        // A word popped this cycle frees its slot before the new read can return.
        credit_ok = (SUM_W'(fifo_cnt_q) + inflight - SUM_W'(pop)) < SUM_W'(FIFO_DEPTH);
        issue = (state_q == StFetch) && credit_ok;
        vpipe_d = vpipe_q << 1;
        vpipe_d[0] = issue;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            issue_cnt_q <= '0;
            ram_addr_q  <= '0;
            vpipe_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            out_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            csum_q      <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            vpipe_q <= vpipe_d;
            done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (START) begin
                        state_q     <= StFetch;
                        busy_q      <= 1'b1;
                        ram_addr_q  <= BASE_ADDR;
                        issue_cnt_q <= '0;
                        out_idx_q   <= '0;
                        csum_q      <= '0;
                    end
                end
                StFetch: begin
                    if (issue) begin
                        issue_cnt_q <= issue_cnt_q + ISS_W'(1);
                        // Address of the final read is held once issuing stops.
                        if (issue_cnt_q == LAST_ISSUE) begin
                            state_q <= StDrain;
                        end else begin
                            ram_addr_q <= ram_addr_q + WORD_STRIDE;
                        end
                    end
                end
                StDrain: begin
                    if (pop && OUT_LAST) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (push) begin
                fifo_mem_q[wr_ptr_q] <= RAM_Q;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
                out_idx_q <= out_idx_q + 8'd1;
                csum_q    <= csum_q + OUT_DATA;
            end
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign RAM_ADDR  = ram_addr_q;
    assign OUT_VALID = (fifo_cnt_q != '0);
    assign OUT_DATA  = fifo_mem_q[rd_ptr_q];
    assign OUT_INDEX = out_idx_q;
    assign OUT_LAST  = (out_idx_q == LAST_IDX);
    assign BUSY      = busy_q;
    assign DONE      = done_q;

`ifdef UNLOAD_CHECKSUM_EN
    assign CHECKSUM = csum_q;
`else
    logic unused_csum;
    assign unused_csum = ^csum_q;
`endif

endmodule

// File: tb/tb_gpu_result_unloader.sv
// Scoreboard bench for gpu_result_unloader: RD_LAT=1 instance for most scenarios,
// RD_LAT=3 instance for the latency sweep.
module tb_gpu_result_unloader;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  i;
        logic        l;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] ram_addr;
    logic [31:0] ram_q;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;

    logic        rst_b;
    logic        start_b;
    logic [31:0] ram_addr_b;
    logic [31:0] ram_q_b;
    logic [31:0] r1_b;
    logic [31:0] r2_b;
    logic        out_valid_b;
    logic        out_ready_b;
    logic [31:0] out_data_b;
    logic [7:0]  out_index_b;
    logic        out_last_b;
    logic        busy_b;
    logic        done_b;
`ifdef UNLOAD_CHECKSUM_EN
    logic [31:0] csum;
    logic [31:0] csum_b;
`endif

    int   errors = 0;
    int   checks = 0;
    int   ready_mode = 0;
    bit   data_neg = 0;
    bit   b_fin = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];

    gpu_result_unloader #(.NUM_WORDS(256), .WORD_STRIDE(4), .RD_LAT(1), .FIFO_DEPTH(4)) dut_a (
        .CLK(clk), .RESET(rst), .START(start), .BASE_ADDR(base_addr),
        .RAM_ADDR(ram_addr), .RAM_Q(ram_q),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
        .OUT_INDEX(out_index), .OUT_LAST(out_last), .BUSY(busy), .DONE(done)
`ifdef UNLOAD_CHECKSUM_EN
        , .CHECKSUM(csum)
`endif
    );

    gpu_result_unloader #(.NUM_WORDS(256), .WORD_STRIDE(4), .RD_LAT(3), .FIFO_DEPTH(4)) dut_b (
        .CLK(clk), .RESET(rst_b), .START(start_b), .BASE_ADDR(base_addr),
        .RAM_ADDR(ram_addr_b), .RAM_Q(ram_q_b),
        .OUT_VALID(out_valid_b), .OUT_READY(out_ready_b), .OUT_DATA(out_data_b),
        .OUT_INDEX(out_index_b), .OUT_LAST(out_last_b), .BUSY(busy_b), .DONE(done_b)
`ifdef UNLOAD_CHECKSUM_EN
        , .CHECKSUM(csum_b)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ram_val(input logic [31:0] addr);
        if (data_neg) return 32'hFFFF_FFFF;
        return ((addr - 32'd6144) >> 2) * 32'd3;
    endfunction

    // RAM models: one-cycle and three-cycle read latency.
    always @(posedge clk) begin
        ram_q <= ram_val(ram_addr);
        r1_b  <= ram_val(ram_addr_b);
        r2_b  <= r1_b;
        ram_q_b <= r2_b;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = (cyc % 4 == 0);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            cyc++;
        end
    end

    // Monitor A: pops the scoreboard on each handshake, checks stall stability and DONE timing.
    initial begin
        bit   prev_stall;
        bit   exp_done;
        exp_t held;
        exp_t e;
        prev_stall = 0;
        exp_done = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                exp_done = 0;
            end else begin
                if (done || exp_done) chk("done_a", 32'(done), 32'(exp_done));
                exp_done = 0;
                if (prev_stall) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_data", out_data, held.d);
                    chk("stall_index", 32'(out_index), 32'(held.i));
                    chk("stall_last", 32'(out_last), 32'(held.l));
                end
                if (out_valid && out_ready) begin
                    if (sb_a.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word_a: got index %0d data %0h, want none",
                                 out_index, out_data);
                    end else begin
                        e = sb_a.pop_front();
                        chk("data_a", out_data, e.d);
                        chk("index_a", 32'(out_index), 32'(e.i));
                        chk("last_a", 32'(out_last), 32'(e.l));
                        exp_done = e.l;
                    end
                end
                prev_stall = out_valid && !out_ready;
                held.d = out_data;
                held.i = out_index;
                held.l = out_last;
            end
        end
    end

    initial begin
        bit   exp_done;
        exp_t e;
        exp_done = 0;
        forever begin
            @(negedge clk);
            if (rst_b) begin
                exp_done = 0;
            end else begin
                if (done_b || exp_done) chk("done_b", 32'(done_b), 32'(exp_done));
                exp_done = 0;
                if (out_valid_b) begin
                    if (sb_b.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word_b: got index %0d, want none", out_index_b);
                    end else begin
                        e = sb_b.pop_front();
                        chk("data_b", out_data_b, e.d);
                        chk("index_b", 32'(out_index_b), 32'(e.i));
                        chk("last_b", 32'(out_last_b), 32'(e.l));
                        exp_done = e.l;
                    end
                end
            end
        end
    end

    function automatic exp_t mk(input int k);
        exp_t e;
        e.d = data_neg ? 32'hFFFF_FFFF : 32'(k * 3);
        e.i = 8'(k);
        e.l = (k == 255);
        return e;
    endfunction

    task automatic start_a();
        int lat;
        for (int k = 0; k < 256; k++) sb_a.push_back(mk(k));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("first_valid_lat_a", 32'(lat), 32'd2);
    endtask

    // Returns in the DONE cycle (or after the budget expires).
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("busy_low_at_done", 32'(busy), 32'd0);
        chk("all_words_seen", 32'(sb_a.size()), 32'd0);
    endtask

    task automatic wait_idx(input int v);
        int n;
        n = 0;
        while (!(out_valid && out_index == 8'(v)) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_index", 32'(out_index), 32'(v));
    endtask

    task automatic chk_reset_vals();
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
`ifdef UNLOAD_CHECKSUM_EN
        chk("rst_checksum", csum, 32'd0);
`endif
    endtask

    // Latency sweep on the RD_LAT=3 instance.
    initial begin
        int lat;
        int n;
        rst_b = 1'b1;
        start_b = 1'b0;
        out_ready_b = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 256; k++) sb_b.push_back(mk(k));
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        lat = 0;
        while (!out_valid_b && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("first_valid_lat_b", 32'(lat), 32'd4);
        n = 0;
        while (!done_b && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("throughput_b", 32'(n), 32'd256);
        chk("all_words_seen_b", 32'(sb_b.size()), 32'd0);
        b_fin = 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  stray;
        rst = 1'b1;
        start = 1'b0;
        base_addr = 32'd6144;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic unload, ready always high.
        start_a();
        wait_done(n);
        chk("throughput_a", 32'(n), 32'd256);
`ifdef UNLOAD_CHECKSUM_EN
        chk("checksum_basic", csum, 32'd97920);
        repeat (3) @(posedge clk);
        #1;
        chk("checksum_hold", csum, 32'd97920);
`endif
        chk("ram_addr_last", ram_addr, 32'd6144 + 32'd4 * 32'd255);

        // Backpressure: 1-high/3-low pattern, then random.
        ready_mode = 1;
        start_a();
        wait_done(n);
        ready_mode = 2;
        start_a();
        wait_done(n);
        ready_mode = 0;
        @(posedge clk);
        #1;

        // START mid-unload is ignored; START in the DONE cycle is accepted.
        start_a();
        wait_idx(100);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_ignored_start", 32'(busy), 32'd1);
        wait_done(n);
        start_a();
        wait_done(n);
        @(posedge clk);
        #1;

        // Reset mid-unload with reads in flight.
        start_a();
        wait_idx(50);
        rst = 1'b1;
        sb_a.delete();
        @(posedge clk);
        #1;
        chk_reset_vals();
        rst = 1'b0;
        stray = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) stray = 1;
        end
        chk("no_stray_valid", 32'(stray), 32'd0);
        start_a();
        wait_done(n);

        // All-ones words: checksum wraps to 0xFFFFFF00.
        data_neg = 1;
        start_a();
        wait_done(n);
`ifdef UNLOAD_CHECKSUM_EN
        chk("checksum_neg", csum, 32'hFFFF_FF00);
`endif
        data_neg = 0;

        n = 0;
        while (!b_fin && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency_sweep_finished", 32'(b_fin), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpu_result_unloader.md
Name: gpu_result_unloader

Overview:
- Read-side counterpart of the GPU matrix loader: after the cores finish, walks the result region of the unified multiport RAM through one GPU port and streams each 32-bit result word out on a valid/ready interface.
- Sits between the GPU top and the testbench/host sink; replaces the fixed-cycle result capture.
- Handles RAM read latency and sink backpressure with a credit-checked output FIFO.

Parameters:
- NUM_WORDS, 256, words to unload (16x16 result matrix).
- WORD_STRIDE, 4, byte-address increment per word.
- RD_LAT, 1, cycles from RAM_ADDR presented to RAM_Q valid (1..3).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, must be >= RD_LAT+1).

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- START  in  1  one-cycle pulse: begin unload
- BASE_ADDR  in  32  byte address of word 0 (e.g. 6144), sampled on accepted START
- RAM_ADDR  out  32  read address to the RAM GPU port
- RAM_Q  in  32  RAM read data, valid RD_LAT cycles after RAM_ADDR
- OUT_VALID  out  1  stream word valid
- OUT_READY  in  1  sink accepts word
- OUT_DATA  out  32  result word
- OUT_INDEX  out  8  word index 0..NUM_WORDS-1 (row*16+col)
- OUT_LAST  out  1  high with the final word
- BUSY  out  1  high from accepted START until DONE
- DONE  out  1  one-cycle pulse after the last word handshakes

Behaviour:
- Reset: state IDLE; RAM_ADDR=0, OUT_VALID=0, OUT_DATA=0, OUT_INDEX=0, OUT_LAST=0, BUSY=0, DONE=0; FIFO empty; issue/return/output counters=0; in-flight pipe cleared. Reset mid-unload aborts immediately and discards all in-flight data.
- States: IDLE -> FETCH on START. FETCH -> DRAIN when NUM_WORDS reads have been issued. DRAIN -> IDLE when the last word handshakes (OUT_VALID & OUT_READY & OUT_LAST); DONE pulses in the following cycle, and BUSY falls in that same cycle.
- START is ignored unless in IDLE. START in the DONE cycle is accepted.
- Issue rule: in FETCH, issue one read per cycle while inflight+fifo_count < FIFO_DEPTH.
  - RAM_ADDR = BASE_ADDR + WORD_STRIDE*issue_cnt, 32-bit wrap.
  - A RD_LAT-deep valid shift register tracks in-flight reads.
  - Credits guarantee that returned data never overflows the FIFO, so no data is dropped.
- RAM_ADDR holds its last value when no read is issued. Stale RAM_Q is ignored when the valid pipe bit is 0.
- Return: when the valid pipe output is 1, push RAM_Q into the FIFO in the same cycle; FIFO push and pop may occur simultaneously.
- Output: OUT_VALID = FIFO non-empty (registered FIFO head).
  - OUT_DATA, OUT_INDEX and OUT_LAST stay stable while OUT_VALID & !OUT_READY.
  - OUT_INDEX increments per handshake.
  - OUT_LAST = (OUT_INDEX == NUM_WORDS-1).
- Throughput: 1 word/cycle when OUT_READY is held high, with first OUT_VALID RD_LAT+1 cycles after START.
- The FIFO never goes below empty or above FULL; counters are sized with $clog2.

Optional Feature:
- Macro UNLOAD_CHECKSUM_EN.
- When defined, adds output CHECKSUM [31:0]: a modulo-2^32 sum of OUT_DATA over all handshaked words.
  - Cleared on RESET and on accepted START.
  - Final value stable from the DONE cycle until the next START.
- When undefined, the port and adder are absent; all other behaviour is identical.

Test Plan:
- Basic unload: RAM preloaded so that word i at 6144+4i = i*3; BASE_ADDR=6144, START, OUT_READY=1.
  - Expect 256 words 0,3,...,765 with OUT_INDEX 0..255 and OUT_LAST only on index 255.
  - Expect DONE one cycle after that handshake and first OUT_VALID 2 cycles after START (RD_LAT=1).
- Backpressure: OUT_READY toggled 1-cycle high / 3-cycles low, then random.
  - Expect no lost or duplicated words, data held stable while stalled, FIFO count <= 4, and in-order indices.
- Latency sweep: RD_LAT=3, FIFO_DEPTH=4, OUT_READY=1 → same sequence as the basic test, first OUT_VALID 4 cycles after START.
- START handling: START pulsed at word 100 during an unload → ignored, with 256 words total. START in the DONE cycle → second unload begins and repeats all 256 words.
- Reset mid-operation: RESET at word 50 with reads in flight.
  - Expect all outputs at their reset values next cycle and no stray OUT_VALID afterwards.
  - A new START then yields indices starting from 0.
- Checksum (UNLOAD_CHECKSUM_EN): basic-unload data → CHECKSUM = 3*32640 = 97920 at DONE. Negative words 0xFFFFFFFF ×256 → 0xFFFFFF00.
